// File: rtl/ippcrc_crc12_56b_sch_if.sv
// Word-in / CRC-out bundle for the time-multiplexed CRC-12 scheduler.
// Defining IPPCRC_CRC12_CHK_EN adds the expected-CRC input i_crc and the o_err flag.
interface ippcrc_crc12_56b_sch_if #(
   parameter int NCH = 8,
   parameter int CHW = 3
);
   logic           i_vld;
   logic [CHW-1:0] i_chn;
   logic           i_sof;
   logic           i_eof;
   logic [55:0]    i_dat;
   logic           o_vld;
   logic [CHW-1:0] o_chn;
   logic [11:0]    o_crc;
   logic           o_ferr;
   logic [NCH-1:0] o_open;
`ifdef IPPCRC_CRC12_CHK_EN
   logic [11:0]    i_crc;
   logic           o_err;

   modport master (output i_vld, i_chn, i_sof, i_eof, i_dat, i_crc,
                   input  o_vld, o_chn, o_crc, o_ferr, o_open, o_err);
   modport slave  (input  i_vld, i_chn, i_sof, i_eof, i_dat, i_crc,
                   output o_vld, o_chn, o_crc, o_ferr, o_open, o_err);
`else
   modport master (output i_vld, i_chn, i_sof, i_eof, i_dat,
                   input  o_vld, o_chn, o_crc, o_ferr, o_open);
   modport slave  (input  i_vld, i_chn, i_sof, i_eof, i_dat,
                   output o_vld, o_chn, o_crc, o_ferr, o_open);
`endif
endinterface

// File: rtl/ippcrc_crc12_56b_sch.sv
// CRC-12 (x^12+x^11+x^3+x^2+x+1) scheduler: one 56-bit core shared by NCH interleaved channels.
// Optional macro IPPCRC_CRC12_CHK_EN adds i_crc compare and o_err.
module ippcrc_crc12_56b_core (
   input  logic [11:0] ci,
   input  logic [55:0] di,
   output logic [11:0] co
);
   localparam logic [11:0] POLY = 12'h80F;
   logic [11:0] c;
   logic        fb;

   // di[0] enters the LFSR first, di[55] last
   always_comb begin
      c  = ci;
      fb = 1'b0;
      for (int i = 0; i < 56; i++) begin
         fb = c[11] ^ di[i];
         c  = {c[10:0], 1'b0} ^ ({12{fb}} & POLY);
      end
   end
   assign co = c;
endmodule

module ippcrc_crc12_56b_sch #(
   parameter int          NCH      = 8,
   parameter int          CHW      = 3,
   parameter logic [11:0] CRC_INIT = 12'h000,
   parameter logic [11:0] XOR_OUT  = 12'h000
) (
   input logic                  clk,
   input logic                  rst,
   ippcrc_crc12_56b_sch_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} st_e;

   logic           s1_vld_q, s1_sof_q, s1_eof_q, in_rng;
   logic [CHW-1:0] s1_chn_q;
   logic [55:0]    s1_dat_q;
   st_e            st_q [NCH];
   st_e            st_d [NCH];
   logic [11:0]    ctx_q [NCH];
   logic [11:0]    ctx_d [NCH];
   logic           vld_q, vld_d, ferr_q, ferr_d, wr_en;
   logic [CHW-1:0] chn_q, chn_d;
   logic [11:0]    crc_q, crc_d, ci, co, cur_ctx, wr_ctx;
   st_e            cur_st, wr_st;
`ifdef IPPCRC_CRC12_CHK_EN
   logic [11:0]    s1_crc_q;
   logic           err_q, err_d;
`endif

   assign in_rng = ({1'b0, bus.i_chn} < (CHW+1)'(NCH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_sof_q <= 1'b0;
         s1_eof_q <= 1'b0;
         s1_chn_q <= '0;
         s1_dat_q <= '0;
`ifdef IPPCRC_CRC12_CHK_EN
         s1_crc_q <= '0;
`endif
      end else begin
         s1_vld_q <= bus.i_vld & in_rng;
         s1_sof_q <= bus.i_sof;
         s1_eof_q <= bus.i_eof;
         s1_chn_q <= bus.i_chn;
         s1_dat_q <= bus.i_dat;
`ifdef IPPCRC_CRC12_CHK_EN
         s1_crc_q <= bus.i_crc;
`endif
      end
   end

   always_comb begin
      cur_ctx = CRC_INIT;
      cur_st  = IDLE;
      for (int n = 0; n < NCH; n++)
         if (s1_chn_q == CHW'(n)) begin
            cur_ctx = ctx_q[n];
            cur_st  = st_q[n];
         end
   end

   assign ci = s1_sof_q ? CRC_INIT : cur_ctx;

   ippcrc_crc12_56b_core u_core (.ci(ci), .di(s1_dat_q), .co(co));

   // sof on an OPEN channel aborts it and restarts exactly like sof on IDLE
   always_comb begin
      st_d   = st_q;
      ctx_d  = ctx_q;
      vld_d  = 1'b0;
      ferr_d = 1'b0;
      chn_d  = chn_q;
      crc_d  = crc_q;
      wr_en  = 1'b0;
      wr_ctx = cur_ctx;
      wr_st  = cur_st;
      if (s1_vld_q) begin
         if (s1_sof_q || cur_st == OPEN) begin
            wr_en  = 1'b1;
            ferr_d = s1_sof_q && (cur_st == OPEN);
            if (s1_eof_q) begin
               vld_d  = 1'b1;
               crc_d  = co ^ XOR_OUT;
               wr_ctx = CRC_INIT;
               wr_st  = IDLE;
            end else begin
               wr_ctx = co;
               wr_st  = OPEN;
            end
         end else begin
            ferr_d = 1'b1;
         end
         if (vld_d || ferr_d) chn_d = s1_chn_q;
      end
      for (int n = 0; n < NCH; n++)
         if (wr_en && s1_chn_q == CHW'(n)) begin
            ctx_d[n] = wr_ctx;
            st_d[n]  = wr_st;
         end
   end

`ifdef IPPCRC_CRC12_CHK_EN
   assign err_d = vld_d && ((co ^ XOR_OUT) != s1_crc_q);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < NCH; n++) begin
            st_q[n]  <= IDLE;
            ctx_q[n] <= CRC_INIT;
         end
         vld_q  <= 1'b0;
         ferr_q <= 1'b0;
         chn_q  <= '0;
         crc_q  <= '0;
`ifdef IPPCRC_CRC12_CHK_EN
         err_q  <= 1'b0;
`endif
      end else begin
         st_q   <= st_d;
         ctx_q  <= ctx_d;
         vld_q  <= vld_d;
         ferr_q <= ferr_d;
         chn_q  <= chn_d;
         crc_q  <= crc_d;
`ifdef IPPCRC_CRC12_CHK_EN
         err_q  <= err_d;
`endif
      end
   end

   for (genvar n = 0; n < NCH; n++) begin : g_open
      assign bus.o_open[n] = (st_q[n] == OPEN);
   end

   assign bus.o_vld  = vld_q;
   assign bus.o_ferr = ferr_q;
   assign bus.o_chn  = chn_q;
   assign bus.o_crc  = crc_q;
`ifdef IPPCRC_CRC12_CHK_EN
   assign bus.o_err  = err_q;
`endif
endmodule
